// File: rtl/n0prime_hensel_pkg.sv
// Shared types and constants for the n0prime Hensel-lifting generator.
package n0prime_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ITER   = 2'd1,
    CHECK  = 2'd2,
    FINISH = 2'd3
  } state_t;

  localparam int DEF_N_WIDTH = 1024;
  localparam int DEF_W       = 32;

  // Ceiling log2, usable in parameter expressions.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/n0prime_hensel_if.sv
// Request/result bundle between the key loader and the n0prime generator.
interface n0prime_hensel_if
  import n0prime_pkg::*;
#(
  parameter int N_WIDTH = DEF_N_WIDTH,
  parameter int W       = DEF_W
);
  logic               start;
  logic [N_WIDTH-1:0] n;
  logic [W-1:0]       n0prime;
  logic               done;
  logic               busy;
  logic               err;

  modport master (output start, n, input n0prime, done, busy, err);
  modport slave  (input start, n, output n0prime, done, busy, err);
endinterface

// File: rtl/n0prime_hensel_step.sv
// One Hensel lifting step: fixes bit i of y so that a*y == 1 mod 2^(i+1).
module n0prime_step
  import n0prime_pkg::*;
#(
  parameter int W  = DEF_W,
  parameter int IW = clog2(DEF_W)
) (
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  y,
  input  logic [W-1:0]  p,
  input  logic [IW-1:0] i,
  output logic [W-1:0]  y_nxt,
  output logic [W-1:0]  p_nxt
);

  // p tracks a*y mod 2^W, so p[i] is exactly the bit that still needs cancelling.
  always_comb begin
    y_nxt = y;
    p_nxt = p;
    if (p[i]) begin
      y_nxt = y | (W'(1) << i);
      p_nxt = p + (a << i);
    end
  end

endmodule

// File: rtl/n0prime_hensel.sv
// Montgomery constant generator: n0prime = -(n^-1) or n^-1 mod 2^W via bit-serial Hensel lifting.
// Optional build macro N0PRIME_SELFCHECK_EN adds a CHECK state that re-verifies a*y == 1.
module n0prime_hensel
  import n0prime_pkg::*;
#(
  parameter int N_WIDTH = DEF_N_WIDTH,
  parameter int W       = DEF_W,
  parameter bit NEGATE  = 1'b1
) (
  input logic             clk,
  input logic             rst_n,
  n0prime_hensel_if.slave bus
);

  localparam int IW = clog2(W);

  state_t        state, state_n;
  logic [W-1:0]  a, a_n;
  logic [W-1:0]  y, y_n;
  logic [W-1:0]  p, p_n;
  logic [IW-1:0] i, i_n;
  logic [W-1:0]  res, res_n;
  logic          done, done_n;
  logic          busy, busy_n;
  logic          err, err_n;
  logic [W-1:0]  y_step, p_step;

  function automatic logic [W-1:0] mul_lo(input logic [W-1:0] x, input logic [W-1:0] m);
    logic [W-1:0] acc;
    acc = '0;
    for (int k = 0; k < W; k++) begin
      if (m[k]) acc = acc + (x << k);
    end
    return acc;
  endfunction

  n0prime_step #(.W(W), .IW(IW)) u_step (
    .a     (a),
    .y     (y),
    .p     (p),
    .i     (i),
    .y_nxt (y_step),
    .p_nxt (p_step)
  );

  always_comb begin
    state_n = state;
    a_n     = a;
    y_n     = y;
    p_n     = p;
    i_n     = i;
    res_n   = res;
    done_n  = 1'b0;
    busy_n  = busy;
    err_n   = err;
    case (state)
      IDLE: begin
        // The done cycle is spent in IDLE; a start seen then is dropped.
        busy_n = 1'b0;
        if (bus.start && !done) begin
          a_n    = bus.n[W-1:0];
          busy_n = 1'b1;
          if (bus.n[0]) begin
            y_n     = W'(1);
            p_n     = bus.n[W-1:0];
            i_n     = IW'(1);
            err_n   = 1'b0;
            state_n = ITER;
          end else begin
            err_n   = 1'b1;
            state_n = FINISH;
          end
        end
      end
      ITER: begin
        y_n = y_step;
        p_n = p_step;
        if (i == IW'(W - 1)) begin
`ifdef N0PRIME_SELFCHECK_EN
          state_n = CHECK;
`else
          state_n = FINISH;
`endif
        end else begin
          i_n = i + IW'(1);
        end
      end
      CHECK: begin
        if (mul_lo(a, y) != W'(1)) err_n = 1'b1;
        state_n = FINISH;
      end
      FINISH: begin
        if (err)         res_n = '0;
        else if (NEGATE) res_n = ~y + W'(1);
        else             res_n = y;
        done_n  = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a     <= '0;
      y     <= '0;
      p     <= '0;
      i     <= '0;
      res   <= '0;
      done  <= 1'b0;
      busy  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      a     <= a_n;
      y     <= y_n;
      p     <= p_n;
      i     <= i_n;
      res   <= res_n;
      done  <= done_n;
      busy  <= busy_n;
      err   <= err_n;
    end
  end

  assign bus.n0prime = res;
  assign bus.done    = done;
  assign bus.busy    = busy;
  assign bus.err     = err;

endmodule

// File: tb/tb_n0prime_hensel.sv
// Bench for n0prime_hensel: four widths/modes side by side against a Newton-iteration inverse model.
module tb_n0prime_hensel;
  import n0prime_pkg::*;

  localparam int NW = 1024;
`ifdef N0PRIME_SELFCHECK_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif
  localparam int WID [4] = '{32, 32, 64, 2};
  localparam bit NEG [4] = '{1'b1, 1'b0, 1'b1, 1'b1};

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [NW-1:0] n = '0;

  always #5 clk = ~clk;

  n0prime_hensel_if #(.N_WIDTH(NW), .W(32)) ia ();
  n0prime_hensel_if #(.N_WIDTH(NW), .W(32)) ib ();
  n0prime_hensel_if #(.N_WIDTH(NW), .W(64)) ic ();
  n0prime_hensel_if #(.N_WIDTH(NW), .W(2))  id ();

  assign ia.start = start;  assign ia.n = n;
  assign ib.start = start;  assign ib.n = n;
  assign ic.start = start;  assign ic.n = n;
  assign id.start = start;  assign id.n = n;

  n0prime_hensel #(.N_WIDTH(NW), .W(32), .NEGATE(1'b1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));
  n0prime_hensel #(.N_WIDTH(NW), .W(32), .NEGATE(1'b0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));
  n0prime_hensel #(.N_WIDTH(NW), .W(64), .NEGATE(1'b1)) dut_c (.clk(clk), .rst_n(rst_n), .bus(ic));
  n0prime_hensel #(.N_WIDTH(NW), .W(2),  .NEGATE(1'b1)) dut_d (.clk(clk), .rst_n(rst_n), .bus(id));

  logic [3:0]  dn, bz, er;
  logic [63:0] res [4];
  assign dn = {id.done, ic.done, ib.done, ia.done};
  assign bz = {id.busy, ic.busy, ib.busy, ia.busy};
  assign er = {id.err,  ic.err,  ib.err,  ia.err};
  assign res[0] = {32'b0, ia.n0prime};
  assign res[1] = {32'b0, ib.n0prime};
  assign res[2] = ic.n0prime;
  assign res[3] = {62'b0, id.n0prime};

  int          compared = 0;
  int          mismatched = 0;
  int          t_done [4];
  logic [63:0] got [4];
  logic        got_err [4];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] wmask(input int w);
    return (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
  endfunction

  // Newton iteration x <- x*(2 - a*x) doubles the number of correct low bits each pass.
  function automatic logic [63:0] model(input int w, input bit ng, input logic [63:0] a_full);
    logic [63:0] a, x;
    a = a_full & wmask(w);
    if (!a[0]) return 64'd0;
    x = a;
    for (int k = 0; k < 6; k++) x = x * (64'd2 - a * x);
    x = x & wmask(w);
    if (ng) x = (~x + 64'd1) & wmask(w);
    return x;
  endfunction

  function automatic logic [NW-1:0] rand_n();
    logic [NW-1:0] v;
    for (int k = 0; k < NW / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  // Entered and left on a falling edge.
  task automatic run(input logic [NW-1:0] nv, input bit inject);
    int maxt;
    bit all_done;
    logic [63:0] a, m, exp_prod;
    n = nv;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n = rand_n();
    for (int d = 0; d < 4; d++) begin
      t_done[d] = -1;
      check($sformatf("busy_after_accept%0d", d), {63'b0, bz[d]}, 64'd1);
    end
    for (int t = 0; t < 200; t++) begin
      if (t > 0) @(negedge clk);
      if (inject && t == 1) begin n = rand_n() | 1; start = 1'b1; end
      if (inject && t == 2) start = 1'b0;
      for (int d = 0; d < 4; d++) begin
        if (t_done[d] >= 0 && t == t_done[d] + 1) begin
          check($sformatf("busy_clear%0d", d), {63'b0, bz[d]}, 64'd0);
          check($sformatf("done_pulse%0d", d), {63'b0, dn[d]}, 64'd0);
        end
        if (dn[d] && t_done[d] < 0) begin
          t_done[d]  = t;
          got[d]     = res[d];
          got_err[d] = er[d];
          check($sformatf("busy_at_done%0d", d), {63'b0, bz[d]}, 64'd1);
        end
        if (inject && t_done[d] < 0)
          check($sformatf("busy_hold%0d", d), {63'b0, bz[d]}, 64'd1);
      end
      all_done = 1'b1;
      maxt = 0;
      for (int d = 0; d < 4; d++) begin
        if (t_done[d] < 0) all_done = 1'b0;
        else if (t_done[d] > maxt) maxt = t_done[d];
      end
      if (all_done && t >= maxt + 1) break;
    end
    for (int d = 0; d < 4; d++) begin
      m = wmask(WID[d]);
      a = nv[63:0] & m;
      check($sformatf("latency%0d", d), 64'(t_done[d]), nv[0] ? 64'(WID[d] + EXTRA) : 64'd1);
      check($sformatf("err%0d", d), {63'b0, got_err[d]}, {63'b0, ~nv[0]});
      check($sformatf("result%0d", d), got[d], model(WID[d], NEG[d], nv[63:0]));
      if (nv[0]) begin
        exp_prod = NEG[d] ? m : 64'd1;
        check($sformatf("product%0d", d), (a * got[d]) & m, exp_prod);
      end
    end
  endtask

  initial begin
    logic [NW-1:0] nv;
    bit seen_done;
    #1;
    check("rst_res", res[0] | res[1] | res[2] | res[3], 64'd0);
    check("rst_flags", {52'b0, dn, bz, er}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run({{(NW-32){1'b0}}, 32'h0000_0001}, 1'b0);
    check("vec_one_a", got[0], 64'hFFFF_FFFF);
    run({{(NW-32){1'b0}}, 32'h0000_0003}, 1'b0);
    check("vec_three_a", got[0], 64'h5555_5555);
    check("vec_three_b", got[1], 64'hAAAA_AAAB);
    check("vec_three_c", got[2], 64'h5555_5555_5555_5555);
    run({{(NW-32){1'b0}}, 32'hFFFF_FFFF}, 1'b0);
    check("vec_ffff_a", got[0], 64'h1);
    run({{(NW-32){1'b0}}, 32'h0000_0010}, 1'b0);
    check("vec_even_a", got[0], 64'h0);
    run(rand_n() | 1, 1'b0);
    run(rand_n() | 1, 1'b1);
    run(rand_n() & ~NW'(1), 1'b1);

    // Abort mid-iteration (i==10 in the W=32 instances).
    n = rand_n() | 1;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_res", res[0] | res[1] | res[2] | res[3], 64'd0);
    check("abort_flags", {52'b0, dn, bz, er}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 1'b0;
    repeat (80) begin
      @(negedge clk);
      if (dn != 4'b0) seen_done = 1'b1;
    end
    check("abort_no_done", {63'b0, seen_done}, 64'd0);
    run(rand_n() | 1, 1'b0);

    for (int r = 0; r < (EXTRA != 0 ? 1000 : 150); r++) begin
      nv = rand_n();
      if (r % 10 != 9) nv[0] = 1'b1;
      run(nv, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
